// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared state encoding and default word width for the pattern_101 path
package pattern_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int PAT_W = 32;

endpackage

// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - parallel-to-serial front end feeding the pattern_101 detector
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int W         = PAT_W,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic [W-1:0]         in_data,
  input  logic                 in_load,
  input  logic                 in_en,
  output logic                 o_ready,
  output logic                 o_p,
  output logic                 o_p_valid,
  output logic [$clog2(W)-1:0] o_idx,
  output logic                 o_last
);

  localparam int             CW        = $clog2(W);
  localparam logic [CW-1:0]  LAST_CNT  = CW'(W - 1);
  localparam logic [CW-1:0]  FIRST_IDX = LSB_FIRST ? '0 : CW'(W - 1);

  state_t          state;
  logic [W-1:0]    sr;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            load_bit;
  logic [W-1:0]    load_rest;
  logic            next_bit;
  logic [W-1:0]    sr_shifted;

  // A new word may enter while the final bit of the current one is being consumed.
  assign o_ready = (state == ST_IDLE) | ((state == ST_SHIFT) & o_last & in_en);
  assign accept  = in_load & o_ready;

  // The first bit goes straight to o_p, so the shift register only holds what remains.
  assign load_bit   = LSB_FIRST ? in_data[0] : in_data[W-1];
  assign load_rest  = LSB_FIRST ? (in_data >> 1) : (in_data << 1);
  assign next_bit   = LSB_FIRST ? sr[0] : sr[W-1];
  assign sr_shifted = LSB_FIRST ? (sr >> 1) : (sr << 1);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state     <= ST_IDLE;
      sr        <= '0;
      cnt       <= '0;
      o_p       <= 1'b0;
      o_p_valid <= 1'b0;
      o_idx     <= '0;
      o_last    <= 1'b0;
    end else if (accept) begin
      state     <= ST_SHIFT;
      sr        <= load_rest;
      cnt       <= '0;
      o_p       <= load_bit;
      o_p_valid <= 1'b1;
      o_idx     <= FIRST_IDX;
      o_last    <= 1'b0;
    end else if (state == ST_SHIFT && in_en) begin
      if (o_last) begin
        state     <= ST_IDLE;
        o_p       <= 1'b0;
        o_p_valid <= 1'b0;
        o_last    <= 1'b0;
      end else begin
        sr     <= sr_shifted;
        cnt    <= cnt + CW'(1);
        o_p    <= next_bit;
        o_idx  <= LSB_FIRST ? (o_idx + CW'(1)) : (o_idx - CW'(1));
        o_last <= ((cnt + CW'(1)) == LAST_CNT);
      end
    end
  end

endmodule
